// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM state encoding, bit-slot quarter
// phases and R/W bit values.
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_ADDR     = 3'd2,
        S_ADDR_ACK = 3'd3,
        S_DATA     = 3'd4,
        S_DATA_ACK = 3'd5,
        S_STOP     = 3'd6
    } i2c_state_t;

    // Quarter phases of one bit slot: SCL low in Q0-Q1, high in Q2-Q3
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: one-cycle tick on the last clk of each SCL
// quarter. Held at zero while disabled so the first quarter after
// enable is exactly CLK_DIV cycles long.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count 0..CLK_DIV-1 while enabled, wrap at the end of each quarter
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) cnt_d = '0;
        else                      cnt_d = cnt_q + 1'b1;
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK,
// STOP. SDA is open-drain style (drive 0 or release); SCL is push-pull.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       scl,
    inout  wire        sda
);

    i2c_state_t state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] sh_q,    sh_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rw_q,    rw_d;
    logic       nack_q,  nack_d;
    logic       aerr_q,  aerr_d;
    logic       done_q,  done_d;
    logic       tick;
    logic       sda_oe;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != S_IDLE),
        .tick (tick)
    );

    // Next-state: accept in IDLE, sample SDA at end of Q2, advance slot at end of Q3
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        nack_d  = nack_q;
        aerr_d  = aerr_q;
        done_d  = 1'b0;
        if (state_q == S_IDLE) begin
            phase_d = Q0;
            bit_d   = 3'd7;
            if (start) begin
                state_d = S_START;
                sh_d    = {addr, rw};
                rw_d    = rw;
                wdata_d = wdata;
                nack_d  = 1'b0;
                aerr_d  = 1'b0;
            end
        end else if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == Q2) begin
                if (state_q == S_ADDR_ACK || state_q == S_DATA_ACK) nack_d = sda;
                if (state_q == S_DATA && rw_q == RW_READ) sh_d = {sh_q[6:0], sda};
            end
            if (phase_q == Q3) begin
                case (state_q)
                    S_START: state_d = S_ADDR;
                    S_ADDR, S_DATA: begin
                        // read data shifts in at Q2 instead; only outgoing bytes shift here
                        if (state_q == S_ADDR || rw_q == RW_WRITE) sh_d = {sh_q[6:0], 1'b0};
                        if (bit_q == 3'd0) begin
                            bit_d   = 3'd7;
                            state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (nack_q) begin
                            aerr_d  = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            sh_d    = wdata_q;
                            state_d = S_DATA;
                        end
                    end
                    S_DATA_ACK: begin
                        if (rw_q == RW_READ) rdata_d = sh_q;
                        else if (nack_q)     aerr_d  = 1'b1;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= Q0;
            bit_q   <= 3'd7;
            sh_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= RW_WRITE;
            nack_q  <= 1'b0;
            aerr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            nack_q  <= nack_d;
            aerr_q  <= aerr_d;
            done_q  <= done_d;
        end
    end

    // Bus drive decode: SCL pattern per slot, SDA pull-low enable
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_START: sda_oe = (phase_q >= Q2);
            S_ADDR: begin
                scl    = (phase_q >= Q2);
                sda_oe = ~sh_q[7];
            end
            S_DATA: begin
                scl    = (phase_q >= Q2);
                sda_oe = (rw_q == RW_WRITE) && ~sh_q[7];
            end
            S_ADDR_ACK, S_DATA_ACK: scl = (phase_q >= Q2);
            S_STOP: begin
                scl    = (phase_q >= Q2);
                sda_oe = (phase_q != Q3);
            end
            default: ;
        endcase
    end

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign ack_err = aerr_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a behavioural slave at 0x50
// that ACKs its address, accepts writes and returns 0xAA on reads.
module tb_i2c_master_byte;

    localparam int       LIMIT    = 1000;
    localparam logic [6:0] SLV_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst, start, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, ack_err, scl;
    logic [7:0] rdata;
    wire        sda;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_master_byte #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata), .scl(scl), .sda(sda)
    );

    // ---------------- behavioural slave / bus monitor ----------------
    logic       slv_drv = 1'b0;
    logic       pscl = 1'b1, psda = 1'b1;
    logic       started = 1'b0, addressed = 1'b0, rd = 1'b0, m_ack = 1'b0;
    logic [7:0] sbyte = 8'h00;
    logic [7:0] tx = 8'hAA;
    logic [7:0] mon [4];
    int         mon_n = 0, bitn = 0, bidx = 0;
    int         n_start = 0, n_stop = 0, mdrv_err = 0;

    pullup (sda);
    assign sda = slv_drv ? 1'b0 : 1'bz;

    // Sample the bus mid-cycle so simultaneous SCL/SDA moves are never misread as START/STOP
    always @(negedge clk) begin
        if (pscl && scl && psda && !sda) begin
            n_start++; started = 1'b1; bitn = 0; bidx = 0; mon_n = 0; m_ack = 1'b0;
        end else if (pscl && scl && !psda && sda) begin
            n_stop++; started = 1'b0; slv_drv = 1'b0;
        end else if (started && !pscl && scl) begin
            if (bitn < 8) sbyte = {sbyte[6:0], sda};
            else if (bidx == 1) m_ack = sda;
            if (rd && addressed && bidx == 1 && bitn < 8 && !slv_drv && sda == 1'b0) mdrv_err++;
            bitn++;
            if (bitn == 9) begin bitn = 0; bidx++; end
        end else if (started && pscl && !scl) begin
            slv_drv = 1'b0;
            if (bitn == 8) begin
                if (bidx == 0) begin
                    addressed = (sbyte[7:1] == SLV_ADDR);
                    rd        = sbyte[0];
                    slv_drv   = addressed;
                end else if (!rd) begin
                    slv_drv = addressed;
                end
                if (!(bidx == 1 && rd) && mon_n < 4) begin mon[mon_n] = sbyte; mon_n++; end
            end else if (bidx == 1 && rd && addressed && bitn < 8) begin
                slv_drv = ~tx[7-bitn];
            end
        end
        psda = sda;
        pscl = scl;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request now; the next rising edge is the accept edge
    task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d);
        start = 1'b1; rw = r; addr = a; wdata = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges after accept until done; optionally pulse start at edge pulse_at
    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < LIMIT) begin
            @(posedge clk); #1; cyc++;
            if (cyc == pulse_at) begin start = 1'b1; rw = 1'b1; addr = SLV_ADDR; end
            else if (cyc == pulse_at + 1) start = 1'b0;
        end
    endtask

    int  cyc, s0, p0;
    logic done_seen;

    initial begin
        rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;

        // reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_rdata", rdata, 8'h00);
        @(negedge clk); rst = 1'b0;

        // write 0xA5 to 0x50
        @(negedge clk);
        s0 = n_start; p0 = n_stop;
        launch(1'b0, 7'h50, 8'hA5);
        chk("wr_busy_after_accept", busy, 1);
        wait_done(-1, cyc);
        chk("wr_done_cycle", cyc, 320);
        chk("wr_ack_err", ack_err, 0);
        chk("wr_busy_at_done", busy, 0);
        chk("wr_nbytes", mon_n, 2);
        chk("wr_addr_byte", mon[0], 8'hA0);
        chk("wr_data_byte", mon[1], 8'hA5);
        chk("wr_start_seen", n_start - s0, 1);
        chk("wr_stop_seen", n_stop - p0, 1);
        chk("wr_idle_scl", scl, 1);
        chk("wr_idle_sda", sda, 1);
        @(posedge clk); #1;
        chk("wr_done_one_cycle", done, 0);

        // read from 0x50, slave returns 0xAA
        @(negedge clk);
        p0 = n_stop;
        launch(1'b1, 7'h50, 8'h00);
        wait_done(-1, cyc);
        chk("rd_done_cycle", cyc, 320);
        chk("rd_rdata", rdata, 8'hAA);
        chk("rd_ack_err", ack_err, 0);
        chk("rd_addr_byte", mon[0], 8'hA1);
        chk("rd_master_nack", m_ack, 1);
        chk("rd_master_released", mdrv_err, 0);
        chk("rd_stop_seen", n_stop - p0, 1);

        // no slave at 0x3C
        @(negedge clk);
        p0 = n_stop;
        launch(1'b0, 7'h3C, 8'h55);
        wait_done(-1, cyc);
        chk("nack_done_cycle", cyc, 176);
        chk("nack_ack_err", ack_err, 1);
        chk("nack_nbytes", mon_n, 1);
        chk("nack_addr_byte", mon[0], 8'h78);
        chk("nack_stop_seen", n_stop - p0, 1);
        chk("nack_rdata_held", rdata, 8'hAA);

        // start while busy is ignored; start in done cycle is accepted
        @(negedge clk);
        launch(1'b0, 7'h3C, 8'h00);
        wait_done(50, cyc);
        chk("bb1_done_cycle", cyc, 176);
        chk("bb1_ack_err", ack_err, 1);
        chk("bb1_addr_byte", mon[0], 8'h78);
        launch(1'b1, 7'h50, 8'h00);
        chk("bb2_busy_after_accept", busy, 1);
        chk("bb2_ack_err_cleared", ack_err, 0);
        wait_done(-1, cyc);
        chk("bb2_done_cycle", cyc, 320);
        chk("bb2_rdata", rdata, 8'hAA);
        chk("bb2_addr_byte", mon[0], 8'hA1);
        chk("bb2_ack_err", ack_err, 0);

        // reset in DATA bit 3 slot (slot 14 = edges 224..239)
        @(negedge clk);
        launch(1'b0, 7'h50, 8'h5A);
        cyc = 0;
        while (cyc < 230) begin @(posedge clk); #1; cyc++; end
        chk("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ack_err", ack_err, 0);
        chk("mid_rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (400) begin
            @(posedge clk); #1;
            if (done) done_seen = 1'b1;
        end
        chk("mid_rst_no_done", done_seen, 0);
        chk("mid_rst_stays_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte.md
# i2c_master_byte

Synthesizable single-byte I2C master (initiator) that generates START, 7-bit address + R/W, one data byte and STOP on the SCL/SDA bus. It is the bus-driving counterpart of the team's I2C slave/responder model, and the two are used together in the I2C bench. Host logic requests a transfer with a one-cycle `start` pulse and gets a `done` pulse with status and read data. Single master only: no arbitration, no clock stretching, no repeated START.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCL quarter-period; SCL period = 4·`CLK_DIV` cycles; legal range ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  transfer request; accepted only when `busy`=0.
- `rw`  in  1  1 = read, 0 = write; sampled on accept.
- `addr`  in  7  slave address; sampled on accept.
- `wdata`  in  8  write byte; sampled on accept.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse at end of transfer.
- `ack_err`  out  1  status of the last transfer: 1 = NACK seen; valid from `done` until the next accept.
- `rdata`  out  8  byte received in a read; holds until the next read completes.
- `scl`  out  1  I2C clock, driven push-pull by the master.
- `sda`  inout  1  I2C data; the master only drives 0 or releases (`z`); it never drives 1.

## Operation
- Reset values: `scl`=1, `sda`=z, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0, state IDLE.
- States: IDLE → START → ADDR (8 bits) → ADDR_ACK → DATA (8 bits) → DATA_ACK → STOP → IDLE.
- Every bit slot is 4 quarters, Q0..Q3, each `CLK_DIV` cycles long.
  - `scl` is 0 in Q0–Q1 and 1 in Q2–Q3.
  - SDA changes only at the start of Q0.
  - SDA is sampled on the last cycle of Q2.
- START slot: `scl`=1 for all quarters. `sda` is released in Q0–Q1 and driven 0 in Q2–Q3.
- ADDR: shifts out {`addr`,`rw`}, MSB first. A 1 bit means release, a 0 bit means drive 0.
- ADDR_ACK: release `sda` and sample it. Sampled 1 sets `ack_err`=1 and goes straight to STOP, skipping DATA.
- DATA, write (`rw`=0): shifts out `wdata`, MSB first. DATA_ACK releases `sda` and samples it; a sampled 1 sets `ack_err`=1.
- DATA, read (`rw`=1): release `sda` and shift in 8 samples, MSB first. In DATA_ACK the master releases `sda`, which gives a NACK to end the read. `rdata` updates at the end of DATA_ACK.
- STOP slot: `sda` is driven 0 in Q0–Q2 and released in Q3, while `scl` follows the normal slot pattern. SDA therefore rises while SCL is high, which forms the STOP condition.
- `done` pulses on the cycle after the final STOP quarter. `busy` falls in that same cycle and the state is IDLE.
- `start` while `busy`=1 is ignored. `start` in the `done` cycle is accepted.
- `ack_err` clears on accept.

## Timing
- Full transfer: 20 slots = 80·`CLK_DIV` cycles from the accept cycle to `done`. With `CLK_DIV`=4 this is 320 cycles.
- Address NACK: 11 slots = 44·`CLK_DIV` cycles. With `CLK_DIV`=4 this is 176 cycles.
- `busy` rises one cycle after accept, and bus activity starts in that same cycle.
- `rst` mid-transfer:
  - Next cycle: `scl`=1, `sda`=z, `busy`=0, no `done`, `ack_err`=0.
  - A truncated bus sequence is acceptable.
  - `rdata` resets to 0.
- Quarter counter wraps at `CLK_DIV`-1 and the phase counter wraps at 3. The bit counter counts 7 down to 0, then moves to the ACK slot.

## Structure
- Shared package `i2c_pkg` holds:
  - the state encoding (IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP);
  - the quarter-phase constants Q0..Q3;
  - the `RW_READ`/`RW_WRITE` constants.
- One sub-module, `i2c_quarter_tick`: a `CLK_DIV` divider producing a one-cycle `tick` at the end of each quarter, cleared while idle.
- The main FSM, shift register and SDA tristate live in `i2c_master_byte`.

## Test plan
All cases use `CLK_DIV`=4 and an external pull-up on `sda`.
- **Reset:** hold `rst` 2 cycles → `scl`=1, `sda`=z, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0x00.
- **Write, ACKing bench slave:** `addr`=0x50, `rw`=0, `wdata`=0xA5 → bytes 0xA0 then 0xA5 on SCL rising edges, START/STOP present, `done` at cycle 320, `ack_err`=0.
- **Read:** `addr`=0x50, `rw`=1, slave returns 0xAA → address byte 0xA1, `rdata`=0xAA, `sda` released in the 18th bit slot, STOP, `ack_err`=0.
- **No slave present:** write to 0x3C → `ack_err`=1, no data byte, STOP after ADDR_ACK, `done` at cycle 176.
- **`start` while busy, then back-to-back:** pulse `start` mid-transfer → ignored. Pulse `start` in the `done` cycle → accepted, and a second transfer follows.
- **Reset mid-transfer:** assert `rst` during the DATA bit 3 slot → next cycle `scl`=1, `sda`=z, `busy`=0, and `done` never pulses.
